// File: rtl/analyzer_pkg.sv
// Shared types and constants for the analyzer front end.
// Holds the state encoding, config map and default widths.
package analyzer_pkg;

    localparam int DEF_DATA_W = 33;
    localparam int DEF_OFFS_W = 17;
    localparam int DEF_POST_W = 16;
    localparam int NSTAGE     = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_POST   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] F_VALUE  = 2'd0;
    localparam logic [1:0] F_CARE   = 2'd1;
    localparam logic [1:0] F_OFFSET = 2'd2;

    localparam logic [4:0] ADDR_NUM_STAGES = 5'd16;
    localparam logic [4:0] ADDR_POST_LEN   = 5'd17;

    // Zero stages behaves as one; anything above four clamps to four.
    function automatic logic [1:0] last_stage(input logic [2:0] n);
        if (n == 3'd0)
            return 2'd0;
        else if (n >= 3'd4)
            return 2'd3;
        else
            return 2'(n - 3'd1);
    endfunction

endpackage

// File: rtl/trig_cfg_regs.sv
// Trigger configuration register file.
// Writes land only while the caller-supplied gate is open.
import analyzer_pkg::*;

module trig_cfg_regs #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OFFS_W = DEF_OFFS_W,
    parameter int POST_W = DEF_POST_W
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           we,
    input  logic [4:0]                     addr,
    input  logic [DATA_W-1:0]              wdata,
    output logic [NSTAGE-1:0][DATA_W-1:0]  value,
    output logic [NSTAGE-1:0][DATA_W-1:0]  care,
    output logic [NSTAGE-1:0][OFFS_W-1:0]  offset,
    output logic [2:0]                     num_stages,
    output logic [POST_W-1:0]              post_len
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value      <= '0;
            care       <= '0;
            offset     <= '0;
            num_stages <= 3'd1;
            post_len   <= '0;
        end else if (we) begin
            if (!addr[4]) begin
                unique case (addr[1:0])
                    F_VALUE:  value[addr[3:2]]  <= wdata;
                    F_CARE:   care[addr[3:2]]   <= wdata;
                    F_OFFSET: offset[addr[3:2]] <= wdata[OFFS_W-1:0];
                    default: ;
                endcase
            end else if (addr == ADDR_NUM_STAGES) begin
                num_stages <= wdata[2:0];
            end else if (addr == ADDR_POST_LEN) begin
                post_len <= wdata[POST_W-1:0];
            end
        end
    end

endmodule

// File: rtl/trigger_sequencer.sv
// Multi-stage trigger sequencer: walks up to four timed compare
// stages, then counts a post-trigger window before reporting done.
import analyzer_pkg::*;

module trigger_sequencer #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OFFS_W = DEF_OFFS_W,
    parameter int POST_W = DEF_POST_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cfg_we,
    input  logic [4:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] data,
    output logic              armed,
    output logic              capture_en,
    output logic              trig_pulse,
    output logic              done,
    output logic [1:0]        stage,
    output logic [1:0]        state
);

    logic [NSTAGE-1:0][DATA_W-1:0] value;
    logic [NSTAGE-1:0][DATA_W-1:0] care;
    logic [NSTAGE-1:0][OFFS_W-1:0] offset;
    logic [2:0]                    num_stages;
    logic [POST_W-1:0]             post_len;

    state_t            st, st_nx;
    logic [1:0]        stg, stg_nx;
    logic [OFFS_W-1:0] cnt, cnt_nx;
    logic [POST_W-1:0] pcnt, pcnt_nx;
    logic              trig_nx;
    logic              match;
    logic [1:0]        last;

    trig_cfg_regs #(
        .DATA_W(DATA_W),
        .OFFS_W(OFFS_W),
        .POST_W(POST_W)
    ) u_cfg (
        .clock     (clock),
        .reset_n   (reset_n),
        .we        (cfg_we && st == ST_IDLE),
        .addr      (cfg_addr),
        .wdata     (cfg_wdata),
        .value     (value),
        .care      (care),
        .offset    (offset),
        .num_stages(num_stages),
        .post_len  (post_len)
    );

    assign match = ((data ^ value[stg]) & care[stg]) == '0;
    assign last  = last_stage(num_stages);

    always_comb begin
        st_nx   = st;
        stg_nx  = stg;
        cnt_nx  = cnt;
        pcnt_nx = pcnt;
        trig_nx = 1'b0;
        if (abort) begin
            st_nx   = ST_IDLE;
            stg_nx  = 2'd0;
            cnt_nx  = '0;
            pcnt_nx = '0;
        end else begin
            unique case (st)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        st_nx  = ST_SEARCH;
                        stg_nx = 2'd0;
                        cnt_nx = '0;
                    end
                end
                ST_SEARCH: begin
                    if (cnt != offset[stg]) begin
                        cnt_nx = cnt + 1'b1;
                    end else if (!match) begin
                        stg_nx = 2'd0;
                        cnt_nx = '0;
                    end else if (stg != last) begin
                        stg_nx = stg + 1'b1;
                        cnt_nx = '0;
                    end else begin
                        trig_nx = 1'b1;
                        if (post_len == '0) begin
                            st_nx = ST_DONE;
                        end else begin
                            st_nx   = ST_POST;
                            pcnt_nx = POST_W'(1);
                        end
                    end
                end
                ST_POST: begin
                    if (pcnt == post_len)
                        st_nx = ST_DONE;
                    else
                        pcnt_nx = pcnt + 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st         <= ST_IDLE;
            stg        <= 2'd0;
            cnt        <= '0;
            pcnt       <= '0;
            trig_pulse <= 1'b0;
        end else begin
            st         <= st_nx;
            stg        <= stg_nx;
            cnt        <= cnt_nx;
            pcnt       <= pcnt_nx;
            trig_pulse <= trig_nx;
        end
    end

    assign armed      = st == ST_SEARCH;
    assign capture_en = st == ST_SEARCH || st == ST_POST;
    assign done       = st == ST_DONE;
    assign stage      = stg;
    assign state      = st;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Self-checking bench for trigger_sequencer: per-cycle vector tables
// with a scoreboard queue, plus hand-written reset sequences.
module tb_trigger_sequencer;

    localparam int DW = 33;
    localparam logic [DW-1:0] ALL = {DW{1'b1}};

    logic          clock;
    logic          reset_n;
    logic          cfg_we;
    logic [4:0]    cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic          arm;
    logic          abort;
    logic [DW-1:0] data;
    logic          armed;
    logic          capture_en;
    logic          trig_pulse;
    logic          done;
    logic [1:0]    stage;
    logic [1:0]    state;

    trigger_sequencer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .arm       (arm),
        .abort     (abort),
        .data      (data),
        .armed     (armed),
        .capture_en(capture_en),
        .trig_pulse(trig_pulse),
        .done      (done),
        .stage     (stage),
        .state     (state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic          arm;
        logic          abort;
        logic [DW-1:0] data;
        logic [1:0]    e_state;
        logic          e_trig;
        logic          ck_stg;
        logic [1:0]    e_stg;
    } vec_t;

    vec_t tbl[$];
    vec_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic cmp(string nm, int idx, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    function automatic void add(logic a, logic ab, logic [DW-1:0] d,
                                logic [1:0] s, logic t,
                                logic cs, logic [1:0] es);
        vec_t v;
        v.arm     = a;
        v.abort   = ab;
        v.data    = d;
        v.e_state = s;
        v.e_trig  = t;
        v.ck_stg  = cs;
        v.e_stg   = es;
        tbl.push_back(v);
    endfunction

    // Output bundle {state, armed, capture_en, trig_pulse, done}.
    function automatic logic [7:0] act_out();
        return {2'b00, state, armed, capture_en, trig_pulse, done};
    endfunction

    task automatic check_pop(string nm, int idx);
        vec_t e;
        logic [7:0] exp;
        if (sbq.size() == 0) begin
            cmp({nm, "_sbq_empty"}, idx, 8'd1, 8'd0);
            return;
        end
        e = sbq.pop_front();
        exp = {2'b00, e.e_state,
               e.e_state == 2'd1,
               e.e_state == 2'd1 || e.e_state == 2'd2,
               e.e_trig,
               e.e_state == 2'd3};
        cmp(nm, idx, act_out(), exp);
        if (e.ck_stg)
            cmp({nm, "_stage"}, idx, {6'd0, stage}, {6'd0, e.e_stg});
    endtask

    task automatic run_tbl(string nm);
        foreach (tbl[i]) begin
            @(negedge clock);
            arm   = tbl[i].arm;
            abort = tbl[i].abort;
            data  = tbl[i].data;
            sbq.push_back(tbl[i]);
            @(posedge clock);
            #1;
            check_pop(nm, i);
        end
        tbl.delete();
        arm   = 1'b0;
        abort = 1'b0;
    endtask

    task automatic cfgw(logic [4:0] a, logic [DW-1:0] d);
        @(negedge clock);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(posedge clock);
        #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        arm       = 1'b0;
        abort     = 1'b0;
        data      = '0;
        #2 reset_n = 1'b0;
        #1;
        cmp("reset", 0, act_out(), 8'd0);
        cmp("reset_stage", 0, {6'd0, stage}, 8'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // single stage, offset 1
        cfgw(5'd0, 33'd4);
        cfgw(5'd1, ALL);
        cfgw(5'd2, 33'd1);
        add(1, 0, 33'd0, 2'd1, 0, 1, 2'd0);
        add(0, 0, 33'd0, 2'd1, 0, 1, 2'd0);
        add(0, 0, 33'd4, 2'd3, 1, 0, 2'd0);
        add(0, 0, 33'd0, 2'd3, 0, 0, 2'd0);
        add(0, 1, 33'd0, 2'd0, 0, 1, 2'd0);
        run_tbl("single");

        // two stages with restart, then re-arm from DONE
        cfgw(5'd0, 33'hA);
        cfgw(5'd2, 33'd0);
        cfgw(5'd4, 33'hB);
        cfgw(5'd5, ALL);
        cfgw(5'd16, 33'd2);
        add(1, 0, 33'd0, 2'd1, 0, 1, 2'd0);
        add(0, 0, 33'hA, 2'd1, 0, 1, 2'd1);
        add(0, 0, 33'hC, 2'd1, 0, 1, 2'd0);
        add(0, 0, 33'hA, 2'd1, 0, 1, 2'd1);
        add(0, 0, 33'hB, 2'd3, 1, 0, 2'd0);
        add(1, 0, 33'd0, 2'd1, 0, 1, 2'd0);
        add(0, 1, 33'd0, 2'd0, 0, 1, 2'd0);
        run_tbl("restart");

        // post window of 5
        cfgw(5'd16, 33'd1);
        cfgw(5'd0, 33'd5);
        cfgw(5'd17, 33'd5);
        add(1, 0, 33'd0, 2'd1, 0, 0, 2'd0);
        add(0, 0, 33'd5, 2'd2, 1, 0, 2'd0);
        for (int k = 0; k < 4; k++)
            add(0, 0, 33'd0, 2'd2, 0, 0, 2'd0);
        add(0, 0, 33'd0, 2'd3, 0, 0, 2'd0);
        add(0, 0, 33'd0, 2'd3, 0, 0, 2'd0);
        add(0, 1, 33'd0, 2'd0, 0, 1, 2'd0);
        run_tbl("post");

        // don't-care with num_stages=0
        cfgw(5'd1, 33'd0);
        cfgw(5'd16, 33'd0);
        cfgw(5'd17, 33'd0);
        add(1, 0, 33'd0, 2'd1, 0, 1, 2'd0);
        add(0, 0, 33'($urandom), 2'd3, 1, 0, 2'd0);
        add(0, 1, 33'd0, 2'd0, 0, 1, 2'd0);
        run_tbl("dontcare");

        // abort coinciding with final match
        cfgw(5'd1, ALL);
        cfgw(5'd0, 33'd7);
        cfgw(5'd16, 33'd1);
        add(1, 0, 33'd0, 2'd1, 0, 1, 2'd0);
        add(0, 1, 33'd7, 2'd0, 0, 1, 2'd0);
        add(0, 0, 33'd7, 2'd0, 0, 1, 2'd0);
        add(1, 0, 33'd0, 2'd1, 0, 1, 2'd0);
        run_tbl("abort_coll");

        // write while searching must be dropped
        cfgw(5'd0, 33'h55);
        add(0, 1, 33'd0, 2'd0, 0, 1, 2'd0);
        add(1, 0, 33'd0, 2'd1, 0, 1, 2'd0);
        add(0, 0, 33'd7, 2'd3, 1, 0, 2'd0);
        add(0, 1, 33'd0, 2'd0, 0, 1, 2'd0);
        run_tbl("cfg_gate");

        // async reset in the middle of POST
        cfgw(5'd17, 33'd10);
        add(1, 0, 33'd0, 2'd1, 0, 1, 2'd0);
        add(0, 0, 33'd7, 2'd2, 1, 0, 2'd0);
        add(0, 0, 33'd0, 2'd2, 0, 0, 2'd0);
        run_tbl("pre_reset");
        #3 reset_n = 1'b0;
        #1;
        cmp("async_reset", 0, act_out(), 8'd0);
        cmp("async_reset_stage", 0, {6'd0, stage}, 8'd0);
        @(negedge clock);
        reset_n = 1'b1;
        add(1, 0, 33'd0, 2'd1, 0, 1, 2'd0);
        add(0, 0, 33'($urandom), 2'd3, 1, 0, 2'd0);
        add(0, 0, 33'd0, 2'd3, 0, 0, 2'd0);
        run_tbl("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trigger_sequencer.md
# trigger_sequencer

- Multi-stage trigger controller for the analyzer front end.
- Holds a small configuration register file for up to 4 trigger stages.
- Each stage checks the probe bus for one cycle, a programmed number of cycles after the stage is entered. Stages are walked in order; any failed check restarts the sequence at stage 0.
- After the final stage matches, the block counts a programmable post-trigger window, then reports done. The capture buffer uses `capture_en` as its write enable.

## Interface
- `DATA_W`, default 33: probe bus width; also the config write-data width.
- `OFFS_W`, default 17: width of the per-stage offset and of the stage cycle counter.
- `POST_W`, default 16: width of the post-trigger length and counter.
- `clock`, in, 1: single clock; all logic is on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `cfg_we`, in, 1: config write strobe.
- `cfg_addr`, in, 5: config address.
- `cfg_wdata`, in, DATA_W: config write data; LSBs are used for narrower fields.
- `arm`, in, 1: start a trigger search.
- `abort`, in, 1: return to IDLE.
- `data`, in, DATA_W: probe bus.
- `armed`, out, 1: state is SEARCH.
- `capture_en`, out, 1: state is SEARCH or POST.
- `trig_pulse`, out, 1: one-cycle pulse when the trigger fires.
- `done`, out, 1: state is DONE.
- `stage`, out, 2: current stage index.
- `state`, out, 2: IDLE=0, SEARCH=1, POST=2, DONE=3.

## Operation
- **Config map**
  - Address `{s[1:0], f[1:0]}` for s in 0..3 selects a per-stage field: f=0 `value[s]` (DATA_W bits), f=1 `care[s]` (DATA_W bits), f=2 `offset[s]` (OFFS_W bits).
  - Address 16: `num_stages` (3 bits). Address 17: `post_len` (POST_W bits).
  - f=3 and addresses 18–31 are ignored.
  - Writes are accepted only in IDLE; otherwise they are silently dropped.
- **Register reset values:** value=0, care=0 (matches anything), offset=0, num_stages=1, post_len=0.
- **Stage count:** the effective last stage is `L = min(max(num_stages,1),4) - 1`.
- **Match condition:** `((data ^ value[stage]) & care[stage]) == 0`. The compare is combinational; the result is registered.
- **IDLE**
  - arm → SEARCH, with stage=0 and cnt=0.
- **SEARCH** (evaluated every cycle)
  - If `cnt == offset[stage]` and match: if stage == L, the trigger fires; otherwise stage+1 and cnt=0.
  - If `cnt == offset[stage]` and no match: stage=0, cnt=0.
  - Otherwise cnt+1. cnt never exceeds offset, so no wrap is possible.
- **Trigger fires:** trig_pulse=1 on the next cycle. If post_len==0, go to DONE; otherwise go to POST with pcnt=1.
- **POST**
  - When `pcnt == post_len`: go to DONE.
  - Otherwise pcnt+1.
- **DONE**
  - Holds until either: arm → SEARCH (re-arm, stage=0, cnt=0), or abort → IDLE.
- **Priority:** abort > match/advance > arm. Abort wins from any state.
- arm in SEARCH or POST is ignored.
- Config registers are never cleared by abort; only reset_n clears them.

## Timing
- **Reset:** all outputs are 0 and `state` = IDLE while reset_n is low. This includes the async assertion mid-operation; outputs clear immediately, not at the next edge.
- **Arm:** arm sampled at edge E → state=SEARCH, armed=1, capture_en=1 after E.
- **Stage check:** the stage check occurs at the (offset+1)-th edge after stage entry. With offset=0, the check uses data at the first edge after entry.
- **Trigger:** final match sampled at edge T → trig_pulse high for exactly one cycle, [T, T+1).
- **Post window:** capture_en remains high for post_len cycles after T, then falls; done rises at edge T+post_len (T itself when post_len=0).
- **Abort:** abort at edge A → state=IDLE and all status outputs 0 after A. No trig_pulse is produced even if a final match coincides with abort.
- **Re-arm from DONE:** done falls and armed rises on the same edge.

## Structure
- **Package `analyzer_pkg`:**
  - state encoding constants.
  - `DATA_W`, `OFFS_W`, `POST_W` defaults.
  - config address constants (field codes, `ADDR_NUM_STAGES`=16, `ADDR_POST_LEN`=17).
  - stage count (4).
- **Sub-module `trig_cfg_regs`:** the config register file and write decode, with the IDLE write gate supplied as an input. The FSM and counters stay in the top module.

## Test plan
- **Single stage:** num_stages=1, value0=4, care0=all-ones, offset0=1; arm, then drive data=4 on the 2nd post-arm cycle → trig_pulse one cycle later; post_len=0 → done.
- **Sequence restart:** 2 stages (value0=0xA, value1=0xB, offsets 0). Drive 0xA then 0xC → stage returns to 0, no trigger. Then drive 0xA, 0xB → trig_pulse.
- **Post window:** post_len=5 → capture_en stays high exactly 5 cycles after trig_pulse; done asserts on the next edge.
- **Don't-care / num_stages=0:** care0=0, num_stages=0 → trigger on the first SEARCH cycle regardless of data.
- **Abort collision:** abort on the same edge as the final match → IDLE, no trig_pulse. A cfg write during SEARCH does not change the register value (check after abort).
- **Async reset mid-POST:** reset_n low in POST → outputs 0 immediately; config returns to defaults (num_stages=1, offset=0).
